// File: rtl/srio_byte_packer.sv
// srio_byte_packer
//
// Packs left-justified, partially enabled 64-bit beats into full 64-bit output
// words. A packet is a run of beats that ends with in_last. Bytes are appended
// behind a residual of up to 7 bytes, lane 7 first. When a packet ends with more
// than 8 bytes pending, a second word is drained in the FLUSH state.
//
// Optional feature macro: PACKER_BE_CHECK_EN
//   defined   : a beat whose in_be is not of the form 1..10..0 is dropped
//               (accepted, but no bytes, no output, in_last ignored), and
//               err_be sets and stays set until reset.
//   undefined : err_be is tied to 0. The byte count is the number of leading
//               ones in in_be, and any bits after the first zero are ignored.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready. The producer holds valid and its payload until that edge.
// The output register does not change while out_valid && !out_ready.
//
// Ports
//   clk       in   1   sole clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   in_valid  in   1   input beat present
//   in_ready  out  1   input beat accepted when in_valid && in_ready
//   in_be     in   8   left-justified byte enables, bit 7 = lane [63:56]
//   in_addr   in  32   byte address of lane 7
//   in_data   in  64   left-justified data
//   in_last   in   1   final beat of packet
//   out_valid out  1   output word present
//   out_ready in   1   downstream accepts when out_valid && out_ready
//   out_data  out 64   packed data, left-justified
//   out_be    out  8   left-justified enables of out_data
//   out_addr  out 32   start address of the packet the word belongs to
//   out_last  out  1   final word of packet
//   out_len   out 16   packet byte count on the out_last word, otherwise 0
//   err_be    out  1   sticky non-contiguous enable flag
module srio_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_be,
  input  logic [31:0] in_addr,
  input  logic [63:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [7:0]  out_be,
  output logic [31:0] out_addr,
  output logic        out_last,
  output logic [15:0] out_len,
  output logic        err_be
);

  typedef enum logic {ACC, FLUSH} state_t;

  state_t       state;
  logic [3:0]   r;          // residual byte count, 0..7
  logic [63:0]  res_data;   // residual bytes, left-justified, zero below r bytes
  logic [15:0]  pkt_len;    // running byte count of the packet in progress
  logic [31:0]  pkt_addr;   // in_addr of the first beat of the packet in progress
  logic         in_pkt;     // a non-last beat of the current packet was taken
  logic         ready_en;   // holds in_ready low until the first edge after reset

  function automatic logic [3:0] lead_ones(input logic [7:0] be);
    logic [3:0] c;
    logic       run;
    c   = 4'd0;
    run = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (run && be[i]) c = c + 4'd1;
      else              run = 1'b0;
    end
    return c;
  endfunction

  // k leading ones; k = 0..8
  function automatic logic [7:0] lead_mask(input logic [3:0] k);
    return ~(8'hFF >> k);
  endfunction

  logic [3:0]   n;
  logic [7:0]   n_mask;
  logic         be_bad;
  logic         take;
  logic         out_fire;
  logic [63:0]  data_mask;
  logic [127:0] shifted;
  logic [127:0] cat;
  logic [4:0]   total;
  logic [4:0]   total_m8;
  logic [31:0]  word_addr;
  logic [15:0]  len_sum;

  assign in_ready = ready_en && (state == ACC) && (!out_valid || out_ready);
  assign out_fire = out_valid && out_ready;

  always_comb begin
    n         = lead_ones(in_be);
    n_mask    = lead_mask(n);
`ifdef PACKER_BE_CHECK_EN
    be_bad    = (in_be != n_mask);
`else
    be_bad    = 1'b0;
`endif
    take      = in_valid && in_ready && !be_bad;
    data_mask = '0;
    for (int i = 0; i < 8; i++) data_mask[i*8 +: 8] = {8{n_mask[i]}};
    // Place the new bytes directly behind the residual bytes.
    shifted   = {in_data & data_mask, 64'd0} >> {r, 3'b000};
    cat       = {res_data, 64'd0} | shifted;
    total     = {1'b0, r} + {1'b0, n};
    total_m8  = total - 5'd8;
    word_addr = in_pkt ? pkt_addr : in_addr;
    len_sum   = pkt_len + {12'd0, n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      r         <= 4'd0;
      res_data  <= 64'd0;
      pkt_len   <= 16'd0;
      pkt_addr  <= 32'd0;
      in_pkt    <= 1'b0;
      ready_en  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 64'd0;
      out_be    <= 8'd0;
      out_addr  <= 32'd0;
      out_last  <= 1'b0;
      out_len   <= 16'd0;
    end else begin
      ready_en <= 1'b1;
      // A word that leaves without a replacement clears the packet-end fields.
      if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_len   <= 16'd0;
      end
      case (state)
        ACC: begin
          if (take) begin
            if (in_last) begin
              in_pkt    <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= cat[127:64];
              out_addr  <= word_addr;
              if (total <= 5'd8) begin
                out_be   <= lead_mask(total[3:0]);
                out_last <= 1'b1;
                out_len  <= len_sum;
                res_data <= 64'd0;
                r        <= 4'd0;
                pkt_len  <= 16'd0;
              end else begin
                out_be   <= 8'hFF;
                out_last <= 1'b0;
                out_len  <= 16'd0;
                res_data <= cat[63:0];
                r        <= total_m8[3:0];
                pkt_len  <= len_sum;
                state    <= FLUSH;
              end
            end else begin
              in_pkt  <= 1'b1;
              pkt_len <= len_sum;
              if (!in_pkt) pkt_addr <= in_addr;
              if (total >= 5'd8) begin
                out_valid <= 1'b1;
                out_data  <= cat[127:64];
                out_be    <= 8'hFF;
                out_last  <= 1'b0;
                out_len   <= 16'd0;
                out_addr  <= word_addr;
                res_data  <= cat[63:0];
                r         <= total_m8[3:0];
              end else begin
                res_data <= cat[127:64];
                r        <= total[3:0];
              end
            end
          end
        end
        FLUSH: begin
          // The second word replaces the first one on the edge it is taken.
          if (out_fire) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_be    <= lead_mask(r);
            out_last  <= 1'b1;
            out_len   <= pkt_len;
            res_data  <= 64'd0;
            r         <= 4'd0;
            pkt_len   <= 16'd0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

`ifdef PACKER_BE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_be <= 1'b0;
    else if (in_valid && in_ready && be_bad) err_be <= 1'b1;
  end
`else
  assign err_be = 1'b0;
`endif

endmodule

// File: tb/tb_srio_byte_packer.sv
// Directed testbench for srio_byte_packer. A monitor collects every accepted
// output word, and each scenario task compares those words with
// hand-computed values.
module tb_srio_byte_packer;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  be;
    logic        last;
    logic [15:0] len;
    logic [31:0] addr;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_be = 8'd0;
  logic [31:0] in_addr = 32'd0;
  logic [63:0] in_data = 64'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_be;
  logic [31:0] out_addr;
  logic        out_last;
  logic [15:0] out_len;
  logic        err_be;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  word_t obs_q[$];
  int    obs_cyc_q[$];

  srio_byte_packer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_be(in_be),
    .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_be(out_be), .out_addr(out_addr), .out_last(out_last),
    .out_len(out_len), .err_be(err_be)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change #1 after a rising edge, so at the falling edge they already
  // hold the values the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      obs_q.push_back({out_data, out_be, out_last, out_len, out_addr});
      obs_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  // Call #1 after a rising edge. Returns #1 after the edge that took the beat.
  task automatic send_beat(input logic [7:0] be, input logic [31:0] addr,
                           input logic [63:0] data, input logic last);
    int t;
    in_valid = 1'b1; in_be = be; in_addr = addr; in_data = data; in_last = last;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 100);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_beat timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_words(input int k);
    int t;
    t = 0;
    while (obs_q.size() < k && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  function automatic word_t pop_word();
    word_t w;
    w = '0;
    if (obs_q.size() > 0) w = obs_q.pop_front();
    return w;
  endfunction

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [161:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {out_valid, out_data, out_be, out_addr, out_last, out_len, err_be, in_ready};
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL reset_state: got %h required 0", got);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_early: in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_rise: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_full_beats();
    word_t exp_w[3];
    word_t w;
    clear_obs();
    exp_w[0] = {64'h1111_2222_3333_4444, 8'hFF, 1'b0, 16'd0,  32'h0000_1000};
    exp_w[1] = {64'h5555_6666_7777_8888, 8'hFF, 1'b0, 16'd0,  32'h0000_1000};
    exp_w[2] = {64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b1, 16'd24, 32'h0000_1000};
    send_beat(8'hFF, 32'h0000_1000, 64'h1111_2222_3333_4444, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL full_latency: out_valid=%b required 1", out_valid);
    end
    send_beat(8'hFF, 32'h0000_1008, 64'h5555_6666_7777_8888, 1'b0);
    send_beat(8'hFF, 32'h0000_1010, 64'h9999_AAAA_BBBB_CCCC, 1'b1);
    wait_words(3);
    checks++;
    if (obs_q.size() !== 3) begin
      errors++; $display("FAIL full_count: got %0d words required 3", obs_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      w = pop_word();
      checks++;
      if (w !== exp_w[i]) begin
        errors++; $display("FAIL full_word%0d: got %h required %h", i, w, exp_w[i]);
      end
    end
  endtask

  task automatic test_half_beats();
    word_t exp_w;
    word_t w;
    clear_obs();
    exp_w = {64'hAABB_CCDD_EEFF_1122, 8'hFF, 1'b1, 16'd8, 32'h0000_2000};
    send_beat(8'hF0, 32'h0000_2000, 64'hAABB_CCDD_DEAD_BEEF, 1'b0);
    send_beat(8'hF0, 32'h0000_2004, 64'hEEFF_1122_1234_5678, 1'b1);
    wait_words(1);
    checks++;
    if (obs_q.size() !== 1) begin
      errors++; $display("FAIL half_count: got %0d words required 1", obs_q.size());
    end
    w = pop_word();
    checks++;
    if (w !== exp_w) begin
      errors++; $display("FAIL half_word: got %h required %h", w, exp_w);
    end
  endtask

  task automatic test_flush();
    word_t exp_w[2];
    word_t w;
    clear_obs();
    exp_w[0] = {64'h1122_3344_5566_7788, 8'hFF, 1'b0, 16'd0,  32'h0000_3000};
    exp_w[1] = {64'h99AA_BBCC_DD00_0000, 8'hF8, 1'b1, 16'd13, 32'h0000_3000};
    send_beat(8'hFE, 32'h0000_3000, 64'h1122_3344_5566_7799, 1'b0);
    send_beat(8'hFC, 32'h0000_3007, 64'h8899_AABB_CCDD_EEEE, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
    end
    wait_words(2);
    checks++;
    if (obs_q.size() !== 2) begin
      errors++; $display("FAIL flush_count: got %0d words required 2", obs_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      w = pop_word();
      checks++;
      if (w !== exp_w[i]) begin
        errors++; $display("FAIL flush_word%0d: got %h required %h", i, w, exp_w[i]);
      end
    end
  endtask

  task automatic test_empty();
    word_t exp_w;
    word_t w;
    clear_obs();
    exp_w = {64'd0, 8'h00, 1'b1, 16'd0, 32'h0000_4000};
    send_beat(8'h00, 32'h0000_4000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_words(1);
    w = pop_word();
    checks++;
    if (w !== exp_w || obs_q.size() !== 0) begin
      errors++; $display("FAIL empty_word: got %h required %h", w, exp_w);
    end
  endtask

  task automatic test_be_pattern();
    word_t exp_w;
    word_t w;
    clear_obs();
`ifdef PACKER_BE_CHECK_EN
    exp_w = {64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 16'd8, 32'h0000_4200};
    send_beat(8'hB0, 32'h0000_4100, 64'hABCD_EF01_2345_6789, 1'b1);
    checks++;
    if (err_be !== 1'b1) begin
      errors++; $display("FAIL be_err_set: err_be=%b required 1", err_be);
    end
    send_beat(8'hFF, 32'h0000_4200, 64'h0123_4567_89AB_CDEF, 1'b1);
`else
    exp_w = {64'hAB00_0000_0000_0000, 8'h80, 1'b1, 16'd1, 32'h0000_4100};
    send_beat(8'hB0, 32'h0000_4100, 64'hABCD_EF01_2345_6789, 1'b1);
`endif
    wait_words(1);
    checks++;
    if (obs_q.size() !== 1) begin
      errors++; $display("FAIL be_count: got %0d words required 1", obs_q.size());
    end
    w = pop_word();
    checks++;
    if (w !== exp_w) begin
      errors++; $display("FAIL be_word: got %h required %h", w, exp_w);
    end
    checks++;
`ifdef PACKER_BE_CHECK_EN
    if (err_be !== 1'b1) begin
      errors++; $display("FAIL be_err_sticky: err_be=%b required 1", err_be);
    end
`else
    if (err_be !== 1'b0) begin
      errors++; $display("FAIL be_err_tied: err_be=%b required 0", err_be);
    end
`endif
  endtask

  task automatic test_back_to_back();
    word_t exp_w[2];
    word_t w;
    int    c0, c1;
    clear_obs();
    exp_w[0] = {64'hD1D1_D1D1_D1D1_D1D1, 8'hFF, 1'b1, 16'd8, 32'h0000_5000};
    exp_w[1] = {64'hD2D2_D2D2_D2D2_D2D2, 8'hFF, 1'b1, 16'd8, 32'h0000_5100};
    send_beat(8'hFF, 32'h0000_5000, 64'hD1D1_D1D1_D1D1_D1D1, 1'b1);
    send_beat(8'hFF, 32'h0000_5100, 64'hD2D2_D2D2_D2D2_D2D2, 1'b1);
    wait_words(2);
    c0 = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : 0;
    c1 = (obs_cyc_q.size() > 1) ? obs_cyc_q[1] : 0;
    checks++;
    if (obs_cyc_q.size() !== 2 || c1 - c0 !== 1) begin
      errors++; $display("FAIL b2b_spacing: got %0d cycles required 1", c1 - c0);
    end
    for (int i = 0; i < 2; i++) begin
      w = pop_word();
      checks++;
      if (w !== exp_w[i]) begin
        errors++; $display("FAIL b2b_word%0d: got %h required %h", i, w, exp_w[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    word_t        exp_w[2];
    word_t        w;
    logic [74:0]  got;
    logic [74:0]  req;
    int           t;
    clear_obs();
    exp_w[0] = {64'hCAFE_F00D_1234_5678, 8'hFF, 1'b1, 16'd8, 32'h0000_6000};
    exp_w[1] = {64'h0F0F_0F0F_F0F0_F0F0, 8'hFF, 1'b1, 16'd8, 32'h0000_7000};
    req = {1'b1, 64'hCAFE_F00D_1234_5678, 8'hFF, 1'b1, 1'b0};
    out_ready = 1'b0;
    send_beat(8'hFF, 32'h0000_6000, 64'hCAFE_F00D_1234_5678, 1'b1);
    in_valid = 1'b1; in_be = 8'hFF; in_addr = 32'h0000_7000;
    in_data = 64'h0F0F_0F0F_F0F0_F0F0; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = {out_valid, out_data, out_be, out_last, in_ready};
      checks++;
      if (got !== req) begin
        errors++; $display("FAIL stall_cycle%0d: got %h required %h", i, got, req);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 100);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    wait_words(2);
    checks++;
    if (obs_q.size() !== 2) begin
      errors++; $display("FAIL stall_count: got %0d words required 2", obs_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      w = pop_word();
      checks++;
      if (w !== exp_w[i]) begin
        errors++; $display("FAIL stall_word%0d: got %h required %h", i, w, exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    word_t        exp_w;
    word_t        w;
    logic [161:0] got;
    clear_obs();
    exp_w = {64'h5A5A_5A5A_A5A5_A5A5, 8'hFF, 1'b1, 16'd8, 32'h0000_9000};
    send_beat(8'hF8, 32'h0000_8000, 64'h1020_3040_5000_0000, 1'b0);
    rst_n = 1'b0;
    #1;
    got = {out_valid, out_data, out_be, out_addr, out_last, out_len, err_be, in_ready};
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL midreset_state: got %h required 0", got);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_ready_early: in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    send_beat(8'hFF, 32'h0000_9000, 64'h5A5A_5A5A_A5A5_A5A5, 1'b1);
    wait_words(1);
    checks++;
    if (obs_q.size() !== 1) begin
      errors++; $display("FAIL midreset_count: got %0d words required 1", obs_q.size());
    end
    w = pop_word();
    checks++;
    if (w !== exp_w) begin
      errors++; $display("FAIL midreset_word: got %h required %h", w, exp_w);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_beats();
    test_half_beats();
    test_flush();
    test_empty();
    test_be_pattern();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/srio_byte_packer.md
SRIO_BYTE_PACKER -- requirements
Module: srio_byte_packer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be: clk  in  1  sole clock, all logic on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 in_valid  in  1  input beat present; in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-004 in_be  in  8  left-justified byte enables, bit 7 = byte lane [63:56]; in_addr  in  32  byte address of lane 7; in_data  in  64  left-justified data; in_last  in  1  final beat of packet.
REQ-005 out_valid  out  1  output word present; out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-006 out_data  out  64  packed data, left-justified; out_be  out  8  left-justified enables; out_addr  out  32  start address of current packet; out_last  out  1  final word of packet; out_len  out  16  packet byte count, valid when out_last=1, else 0.
REQ-007 err_be  out  1  sticky flag for non-contiguous enables (see Configuration).

Function
REQ-010 Beat byte count n SHALL equal the number of leading ones in in_be (0..8); an in_be of 8'h00 SHALL be accepted and contribute no bytes.
REQ-011 The block SHALL hold a residual register of r bytes (0..7), left-justified; on acceptance, bytes SHALL be appended after the residual in order lane 7 first.
REQ-012 If r+n >= 8 on a non-last beat: the first 8 bytes SHALL be registered to out_data with out_be=8'hFF, out_last=0, and r SHALL become r+n-8 next cycle.
REQ-013 If r+n < 8 on a non-last beat: no output, r SHALL become r+n.
REQ-014 On a last beat with r+n <= 8: one word SHALL be emitted with out_be = r+n leading ones, out_last=1; r+n=0 SHALL emit out_be=8'h00, out_last=1.
REQ-015 On a last beat with r+n > 8: state SHALL go ACC->FLUSH; first word out_be=8'hFF, out_last=0; in FLUSH, after that word is accepted, remaining r+n-8 bytes SHALL be emitted with out_last=1, then return to ACC with r=0.
REQ-016 States: ACC (accepting), FLUSH (draining second word, in_ready=0); no other states.
REQ-017 in_ready SHALL be (state==ACC) && (!out_valid || out_ready); output register SHALL hold stable while out_valid && !out_ready.
REQ-018 Latency: accepted beat producing a word SHALL assert out_valid on the next rising edge.
REQ-019 out_addr SHALL capture in_addr of the first accepted beat of each packet and hold until the out_last word is accepted.
REQ-020 out_len SHALL be a 16-bit running sum of n per packet; wraps modulo 2^16; cleared after out_last word accepted.
REQ-021 Back-to-back packets SHALL be supported with no idle cycle when out_ready=1 and no FLUSH is required.

Reset
REQ-030 While rst_n=0: state=ACC, r=0, out_valid=0, out_data=0, out_be=0, out_addr=0, out_last=0, out_len=0, err_be=0, in_ready=0.
REQ-031 Reset asserted mid-packet SHALL discard residual and pending output with no further out_valid.
REQ-032 in_ready SHALL rise no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-040 Macro PACKER_BE_CHECK_EN: when defined, a beat whose in_be is not of form 1..10..0 SHALL be dropped (no bytes, no output, in_last ignored) and err_be SHALL set and stay 1 until reset.
REQ-041 Without PACKER_BE_CHECK_EN: err_be SHALL be tied 0 and n SHALL be the leading-ones count regardless of trailing bits.

Verification
REQ-050 Three beats in_be=8'hFF, data A,B,C, last on C, out_ready=1 -> three words out_be=8'hFF, last word out_last=1, out_len=24, out_addr=first in_addr.
REQ-051 Beats in_be=8'hF0 (AABBCCDD), 8'hF0 (EEFF1122, last) -> one word 64'hAABBCCDDEEFF1122, out_be=8'hFF, out_last=1, out_len=8.
REQ-052 Beats in_be=8'hFE then 8'hFC last -> word 1 out_be=8'hFF out_last=0, FLUSH, word 2 out_be=8'hF8 out_last=1, in_ready=0 during FLUSH, out_len=13.
REQ-053 out_ready held 0 for 5 cycles with out_valid=1 -> out_data/out_be/out_last stable, in_ready=0, no beat lost.
REQ-054 With PACKER_BE_CHECK_EN, in_be=8'hB0 -> beat dropped, err_be=1 next cycle and sticky; without macro -> counted as n=1.
REQ-055 rst_n pulsed low with r=5 mid-packet -> all outputs zero per REQ-030; next packet in_be=8'hFF last -> single word out_len=8.
